// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pipelined_cla_adder: SEG-stage segmented adder, 4-bit CLA groups/stage,    |
// | valid/ready flow control. Optional o_overflow under CLA_OVERFLOW_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pipelined_cla_adder #(
   parameter int BIT = 32,
   parameter int SEG = 4
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   input  logic           i_valid,
   output logic           o_ready,
   input  logic [BIT-1:0] i_data_a,
   input  logic [BIT-1:0] i_data_b,
   input  logic           i_carry,
   output logic           o_valid,
   input  logic           i_ready,
   output logic [BIT-1:0] o_data_s,
   output logic           o_carry
`ifdef CLA_OVERFLOW_EN
   ,
   output logic           o_overflow
`endif
);

   localparam int W    = BIT / SEG;
   localparam int NGRP = W / 4;

   logic w_advance;

   // Group lookahead: each nibble's carries and carry-out come straight from g/p and the group carry-in.
   function automatic logic [W:0] f_cla_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin);
      logic [W-1:0] g, p, s;
      logic [3:0]   gg, pp;
      logic [4:0]   cg;
      logic         c;
      g = a & b;
      p = a ^ b;
      s = '0;
      c = cin;
      for (int j = 0; j < NGRP; j++) begin
         gg    = g[4*j +: 4];
         pp    = p[4*j +: 4];
         cg[0] = c;
         cg[1] = gg[0] | (pp[0] & c);
         cg[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c);
         cg[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c);
         cg[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) | (pp[3] & pp[2] & pp[1] & gg[0])
               | (&pp & c);
         s[4*j +: 4] = pp ^ cg[3:0];
         c = cg[4];
      end
      return {c, s};
   endfunction

   for (genvar k = 0; k < SEG; k++) begin : g_stage
      localparam int REM_IN  = BIT - k * W;
      localparam int REM_OUT = REM_IN - W;
      localparam int SUM_W   = (k + 1) * W;

      logic [REM_IN-1:0] w_a_in, w_b_in;
      logic              w_c_in, w_v_in;
      logic [W:0]        w_add;
      logic [SUM_W-1:0]  w_s_d;
      logic [SUM_W-1:0]  r_s_q;
      logic              r_c_q, r_v_q;

      if (k == 0) begin : g_head
         assign w_a_in = i_data_a;
         assign w_b_in = i_data_b;
         assign w_c_in = i_carry;
         assign w_v_in = i_valid;
         assign w_s_d  = w_add[W-1:0];
      end else begin : g_body
         assign w_a_in = g_stage[k-1].g_fwd.r_a_q;
         assign w_b_in = g_stage[k-1].g_fwd.r_b_q;
         assign w_c_in = g_stage[k-1].r_c_q;
         assign w_v_in = g_stage[k-1].r_v_q;
         assign w_s_d  = {w_add[W-1:0], g_stage[k-1].r_s_q};
      end

      assign w_add = f_cla_add(w_a_in[W-1:0], w_b_in[W-1:0], w_c_in);

      // Data loads only behind a valid token, so bubbles leave the outputs untouched.
      always_ff @(posedge i_clk or negedge i_rstn) begin
         if (!i_rstn) begin
            r_v_q <= 1'b0;
            r_c_q <= 1'b0;
            r_s_q <= '0;
         end else if (w_advance) begin
            r_v_q <= w_v_in;
            if (w_v_in) begin
               r_c_q <= w_add[W];
               r_s_q <= w_s_d;
            end
         end
      end

      if (k < SEG - 1) begin : g_fwd
         logic [REM_OUT-1:0] r_a_q, r_b_q;
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_a_q <= '0;
               r_b_q <= '0;
            end else if (w_advance && w_v_in) begin
               r_a_q <= w_a_in[REM_IN-1:W];
               r_b_q <= w_b_in[REM_IN-1:W];
            end
         end
      end

`ifdef CLA_OVERFLOW_EN
      if (k == SEG - 1) begin : g_ovf
         logic r_ovf_q;
         always_ff @(posedge i_clk or negedge i_rstn) begin
            if (!i_rstn) begin
               r_ovf_q <= 1'b0;
            end else if (w_advance && w_v_in) begin
               r_ovf_q <= (w_a_in[W-1] == w_b_in[W-1]) && (w_add[W-1] != w_a_in[W-1]);
            end
         end
      end
`endif
   end

   assign o_valid   = g_stage[SEG-1].r_v_q;
   assign o_data_s  = g_stage[SEG-1].r_s_q;
   assign o_carry   = g_stage[SEG-1].r_c_q;
   assign w_advance = !o_valid || i_ready;
   assign o_ready   = w_advance;
`ifdef CLA_OVERFLOW_EN
   assign o_overflow = g_stage[SEG-1].g_ovf.r_ovf_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipelined_cla_adder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pipelined_cla_adder: randomized bench with a queue-based a+b+cin model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_pipelined_cla_adder;
   localparam int BIT = 32;
   parameter  int SEG = 4;

   logic           clk = 1'b0;
   logic           rstn;
   logic           i_valid, i_ready, i_carry;
   logic [BIT-1:0] i_data_a, i_data_b;
   logic           o_ready, o_valid, o_carry;
   logic [BIT-1:0] o_data_s;
`ifdef CLA_OVERFLOW_EN
   logic           o_overflow;
`endif

   pipelined_cla_adder #(.BIT(BIT), .SEG(SEG)) dut (
      .i_clk      (clk),
      .i_rstn     (rstn),
      .i_valid    (i_valid),
      .o_ready    (o_ready),
      .i_data_a   (i_data_a),
      .i_data_b   (i_data_b),
      .i_carry    (i_carry),
      .o_valid    (o_valid),
      .i_ready    (i_ready),
      .o_data_s   (o_data_s),
      .o_carry    (o_carry)
`ifdef CLA_OVERFLOW_EN
      ,
      .o_overflow (o_overflow)
`endif
   );

   always #5 clk = ~clk;

   int             n_tests = 0;
   int             n_fail  = 0;
   logic [BIT+1:0] exp_q[$];
   int             n_out = 0, streak = 0, max_streak = 0;
   logic           prev_known = 1'b0, prev_v, prev_rdy, prev_c;
   logic [BIT-1:0] prev_s;

   // Model result: {overflow, carry, sum}
   function automatic logic [BIT+1:0] model(input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                                            input logic c);
      logic [BIT:0] full;
      logic         ovf;
      full = {1'b0, a} + {1'b0, b} + {{BIT{1'b0}}, c};
      ovf  = (a[BIT-1] == b[BIT-1]) && (full[BIT-1] != a[BIT-1]);
      return {ovf, full};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic randomize_inputs();
      i_data_a = BIT'($urandom);
      i_data_b = BIT'($urandom);
      i_carry  = 1'($urandom);
   endtask

   // One clock: scoreboard the handshakes visible now, then advance to the next falling edge.
   task automatic cycle();
      logic [BIT+1:0] e;
      #1;
      if (prev_known) begin
         if (prev_v && !prev_rdy) begin
            check("stall_valid_held", o_valid, 1);
            check("stall_sum_held", o_data_s, prev_s);
            check("stall_carry_held", o_carry, prev_c);
         end else if (!o_valid) begin
            check("idle_sum_held", o_data_s, prev_s);
            check("idle_carry_held", o_carry, prev_c);
         end
      end
      if (o_valid && i_ready) begin
         check("o_valid_with_pending", o_valid, (exp_q.size() != 0) ? 1 : 0);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("sum", o_data_s, e[BIT-1:0]);
            check("carry", o_carry, e[BIT]);
`ifdef CLA_OVERFLOW_EN
            check("overflow", o_overflow, e[BIT+1]);
`endif
         end
         n_out++;
         streak++;
         if (streak > max_streak) max_streak = streak;
      end else if (!o_valid) begin
         streak = 0;
      end
      if (i_valid && o_ready) exp_q.push_back(model(i_data_a, i_data_b, i_carry));
      prev_known = 1'b1;
      prev_v     = o_valid;
      prev_rdy   = i_ready;
      prev_s     = o_data_s;
      prev_c     = o_carry;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int guard;
      i_valid = 1'b0;
      i_ready = 1'b1;
      guard   = 0;
      while ((exp_q.size() != 0 || o_valid) && guard < 100) begin
         cycle();
         guard++;
      end
      check("drain_pending", exp_q.size(), 0);
      check("drain_o_valid", o_valid, 0);
   endtask

   // Hold reset for n cycles from a falling edge while offering a valid input that must be ignored.
   task automatic pulse_reset(input int n);
      i_valid = 1'b1;
      randomize_inputs();
      rstn = 1'b0;
      #1;
      check("rst_o_valid", o_valid, 0);
      check("rst_o_data_s", o_data_s, 0);
      check("rst_o_carry", o_carry, 0);
      check("rst_o_ready", o_ready, 1);
`ifdef CLA_OVERFLOW_EN
      check("rst_o_overflow", o_overflow, 0);
`endif
      exp_q.delete();
      prev_known = 1'b0;
      streak     = 0;
      repeat (n) @(posedge clk);
      @(negedge clk);
      rstn    = 1'b1;
      i_valid = 1'b0;
      #1;
      check("post_rst_o_valid", o_valid, 0);
      check("post_rst_o_ready", o_ready, 1);
   endtask

   // Single isolated operation: measure acceptance-to-o_valid latency and check the literal result.
   task automatic send_one(input string tag, input logic [BIT-1:0] a, input logic [BIT-1:0] b,
                           input logic c, input logic [BIT-1:0] es, input logic ec,
                           input logic eo);
      int lat;
      i_ready  = 1'b1;
      i_valid  = 1'b1;
      i_data_a = a;
      i_data_b = b;
      i_carry  = c;
      check({tag, "_accept"}, o_ready, 1);
      cycle();
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 40) begin
         cycle();
         lat++;
      end
      check({tag, "_latency"}, lat, SEG);
      check({tag, "_sum"}, o_data_s, es);
      check({tag, "_carry"}, o_carry, ec);
`ifdef CLA_OVERFLOW_EN
      check({tag, "_overflow"}, o_overflow, eo);
`else
      if (eo) lat = lat;
`endif
      cycle();
   endtask

   initial begin
      int n0, guard;
      rstn     = 1'b0;
      i_valid  = 1'b0;
      i_ready  = 1'b1;
      i_data_a = '0;
      i_data_b = '0;
      i_carry  = 1'b0;
      @(negedge clk);
      pulse_reset(2);

      send_one("allones_cin", 32'hFFFF_FFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0);
      drain();

      max_streak = 0;
      n0 = n_out;
      i_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         i_valid = 1'b1;
         randomize_inputs();
         cycle();
      end
      drain();
      check("b2b_count", n_out - n0, 10);
      check("b2b_streak", max_streak, 10);

      n0 = n_out;
      i_ready = 1'b1;
      i_valid = 1'b1;
      guard = 0;
      randomize_inputs();
      cycle();
      while (!o_valid && guard < 40) begin
         randomize_inputs();
         cycle();
         guard++;
      end
      check("stall_first_result", o_valid, 1);
      i_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         randomize_inputs();
         #1;
         check("stall_o_ready", o_ready, 0);
         cycle();
      end
      i_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         randomize_inputs();
         cycle();
      end
      drain();
      check("stall_results", n_out - n0, SEG + 6);

      for (int i = 0; i < 80; i++) begin
         i_valid = 1'($urandom);
         i_ready = ($urandom_range(0, 3) != 0);
         randomize_inputs();
         cycle();
      end
      drain();

      i_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_valid = 1'b1;
         randomize_inputs();
         cycle();
      end
      pulse_reset(1);
      send_one("after_rst", 32'h1, 32'h2, 1'b0, 32'h3, 1'b0, 1'b0);
      drain();

      send_one("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
      send_one("neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
